// File: rtl/display_mode_ctrl_if.sv
// Button/tick inputs and display/status outputs of the display mode controller.
interface display_mode_ctrl_if;
  logic       tick_1hz;
  logic       power_btn;
  logic       menu_btn;
  logic       clean_btn;
  logic [2:0] state;
  logic [1:0] disp_sel;
  logic       power_led;
  logic       clean_active;
  logic       clean_done_ind;
  logic [7:0] remaining_sec;

  // Stimulus side: drives the tick and buttons, observes status.
  modport master (
    output tick_1hz, power_btn, menu_btn, clean_btn,
    input  state, disp_sel, power_led, clean_active, clean_done_ind, remaining_sec
  );

  // Controller side.
  modport slave (
    input  tick_1hz, power_btn, menu_btn, clean_btn,
    output state, disp_sel, power_led, clean_active, clean_done_ind, remaining_sec
  );
endinterface

// File: rtl/display_mode_ctrl.sv
// Display mode controller: power/menu/clean buttons, idle timeout and
// self-clean countdown driven by a 1 Hz tick. All outputs registered.
module display_mode_ctrl #(
  parameter int unsigned CLEAN_SECS   = 180,
  parameter int unsigned IDLE_TIMEOUT = 30,
  parameter int unsigned DONE_HOLD    = 5
) (
  input  logic                clk,
  input  logic                rst,
  display_mode_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_OFF        = 3'd0;
  localparam logic [2:0] S_STANDBY    = 3'd1;
  localparam logic [2:0] S_SHOW_CLOCK = 3'd2;
  localparam logic [2:0] S_CLEANING   = 3'd3;
  localparam logic [2:0] S_CLEAN_DONE = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_nxt_state;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_nxt_rem;
  logic [CNT_W-1:0] r_idle;
  logic [CNT_W-1:0] w_nxt_idle;
  logic [CNT_W-1:0] w_idle_inc;
  logic             r_pwr_prev;
  logic             r_menu_prev;
  logic             r_clean_prev;
  logic             w_pwr_ev;
  logic             w_menu_ev;
  logic             w_clean_ev;
  logic             w_any_ev;
  logic [1:0]       r_disp_sel;
  logic             r_power_led;
  logic             r_clean_active;
  logic             r_clean_done_ind;

  assign w_pwr_ev   = bus.power_btn & ~r_pwr_prev;
  assign w_menu_ev  = bus.menu_btn  & ~r_menu_prev;
  assign w_clean_ev = bus.clean_btn & ~r_clean_prev;
  assign w_any_ev   = w_pwr_ev | w_menu_ev | w_clean_ev;
  assign w_idle_inc = r_idle + CNT_W'(1);

  // Button history; reset high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwr_prev   <= 1'b1;
      r_menu_prev  <= 1'b1;
      r_clean_prev <= 1'b1;
    end else begin
      r_pwr_prev   <= bus.power_btn;
      r_menu_prev  <= bus.menu_btn;
      r_clean_prev <= bus.clean_btn;
    end
  end

  // State, countdown and idle/hold counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_OFF;
      r_rem   <= '0;
      r_idle  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_rem   <= w_nxt_rem;
      r_idle  <= w_nxt_idle;
    end
  end

  // Next state: press priority power > clean > menu, presses beat the tick.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_rem   = r_rem;
    w_nxt_idle  = r_idle;
    case (r_state)
      S_OFF: begin
        if (w_pwr_ev) w_nxt_state = S_STANDBY;
      end
      S_STANDBY, S_SHOW_CLOCK: begin
        if (w_pwr_ev) begin
          w_nxt_state = S_OFF;
        end else if (w_clean_ev) begin
          w_nxt_state = S_CLEANING;
          w_nxt_rem   = CNT_W'(CLEAN_SECS);
        end else if (w_menu_ev) begin
          w_nxt_state = (r_state == S_STANDBY) ? S_SHOW_CLOCK : S_STANDBY;
        end else if (bus.tick_1hz) begin
          w_nxt_idle = w_idle_inc;
          if (w_idle_inc == CNT_W'(IDLE_TIMEOUT)) w_nxt_state = S_OFF;
        end
      end
      S_CLEANING: begin
        if (w_pwr_ev) begin
          w_nxt_state = S_OFF;
          w_nxt_rem   = '0;
        end else if (bus.tick_1hz && !w_any_ev && (r_rem != '0)) begin
          w_nxt_rem = r_rem - CNT_W'(1);
          if (r_rem == CNT_W'(1)) w_nxt_state = S_CLEAN_DONE;
        end
      end
      S_CLEAN_DONE: begin
        if (w_pwr_ev) begin
          w_nxt_state = S_OFF;
        end else if (w_clean_ev || w_menu_ev) begin
          w_nxt_state = S_STANDBY;
        end else if (bus.tick_1hz) begin
          w_nxt_idle = w_idle_inc;
          if (w_idle_inc == CNT_W'(DONE_HOLD)) w_nxt_state = S_STANDBY;
        end
      end
      default: begin
        w_nxt_state = S_OFF;
        w_nxt_rem   = '0;
      end
    endcase
    if ((w_nxt_state != r_state) || w_any_ev) w_nxt_idle = '0;
  end

  // Output decode from the next state so outputs move with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp_sel       <= 2'd0;
      r_power_led      <= 1'b0;
      r_clean_active   <= 1'b0;
      r_clean_done_ind <= 1'b0;
    end else begin
      case (w_nxt_state)
        S_SHOW_CLOCK: r_disp_sel <= 2'd1;
        S_CLEANING:   r_disp_sel <= 2'd2;
        S_CLEAN_DONE: r_disp_sel <= 2'd3;
        default:      r_disp_sel <= 2'd0;
      endcase
      r_power_led      <= (w_nxt_state != S_OFF);
      r_clean_active   <= (w_nxt_state == S_CLEANING);
      r_clean_done_ind <= (w_nxt_state == S_CLEAN_DONE);
    end
  end

  assign bus.state          = r_state;
  assign bus.disp_sel       = r_disp_sel;
  assign bus.power_led      = r_power_led;
  assign bus.clean_active   = r_clean_active;
  assign bus.clean_done_ind = r_clean_done_ind;
  assign bus.remaining_sec  = r_rem;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Bench for display_mode_ctrl: directed cases plus random stimulus against
// an event-level reference model.
module tb_display_mode_ctrl;

  localparam int unsigned CLEAN_SECS   = 3;
  localparam int unsigned IDLE_TIMEOUT = 4;
  localparam int unsigned DONE_HOLD    = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // Reference model: 0 off, 1 standby, 2 clock, 3 cleaning, 4 done.
  int   m_state;
  int   m_rem;
  int   m_idle;
  bit   m_prev_p, m_prev_m, m_prev_c;

  display_mode_ctrl_if u_if ();

  display_mode_ctrl #(
    .CLEAN_SECS   (CLEAN_SECS),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .DONE_HOLD    (DONE_HOLD)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_rem    = 0;
    m_idle   = 0;
    m_prev_p = 1'b1;
    m_prev_m = 1'b1;
    m_prev_c = 1'b1;
  endtask

  // One clock of the behavioural rules.
  task automatic model_step(input bit t, input bit p, input bit m, input bit c);
    bit pe, me, ce;
    int old, limit;
    pe = p && !m_prev_p;
    me = m && !m_prev_m;
    ce = c && !m_prev_c;
    m_prev_p = p; m_prev_m = m; m_prev_c = c;
    old = m_state;
    if (pe) begin
      m_state = (old == 0) ? 1 : 0;
      m_rem   = 0;
    end else if (old == 0) begin
      // only power matters when off
    end else if (ce || me) begin
      if (old == 4) m_state = 1;
      else if (old == 1 || old == 2) begin
        if (ce) begin
          m_state = 3;
          m_rem   = CLEAN_SECS;
        end else m_state = 3 - old;
      end
    end else if (t) begin
      if (old == 3) begin
        if (m_rem > 0) m_rem--;
        if (m_rem == 0) m_state = 4;
      end else begin
        m_idle++;
        limit = (old == 4) ? DONE_HOLD : IDLE_TIMEOUT;
        if (m_idle == limit) m_state = (old == 4) ? 1 : 0;
      end
    end
    if (m_state != old || pe || me || ce) m_idle = 0;
  endtask

  task automatic check_outputs(input string tag);
    int disp_map[5] = '{0, 0, 1, 2, 3};
    check({tag, ".state"}, 32'(u_if.state), 32'(m_state));
    check({tag, ".disp"},  32'(u_if.disp_sel), 32'(disp_map[m_state]));
    check({tag, ".led"},   32'(u_if.power_led), 32'(m_state != 0));
    check({tag, ".act"},   32'(u_if.clean_active), 32'(m_state == 3));
    check({tag, ".done"},  32'(u_if.clean_done_ind), 32'(m_state == 4));
    check({tag, ".rem"},   32'(u_if.remaining_sec), 32'(m_rem));
  endtask

  // Drive one cycle of inputs, then compare against the model after the edge.
  task automatic step(input bit t, input bit p, input bit m, input bit c);
    @(negedge clk);
    u_if.tick_1hz  = t;
    u_if.power_btn = p;
    u_if.menu_btn  = m;
    u_if.clean_btn = c;
    @(posedge clk);
    model_step(t, p, m, c);
    #1;
    check_outputs("step");
  endtask

  // Asynchronous reset; outputs checked while reset is still asserted.
  task automatic do_reset(input bit p, input bit m, input bit c);
    @(negedge clk);
    u_if.tick_1hz  = 1'b0;
    u_if.power_btn = p;
    u_if.menu_btn  = m;
    u_if.clean_btn = c;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check("rst.state_off", 32'(u_if.state), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    u_if.tick_1hz = 1'b0; u_if.power_btn = 1'b0;
    u_if.menu_btn = 1'b0; u_if.clean_btn = 1'b0;
    model_reset();
    do_reset(0, 0, 0);

    // Power on, then menu to clock display.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("pwr_on.state", 32'(u_if.state), 32'd1);
    check("pwr_on.disp", 32'(u_if.disp_sel), 32'd0);
    check("pwr_on.led", 32'(u_if.power_led), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("menu.state", 32'(u_if.state), 32'd2);
    check("menu.disp", 32'(u_if.disp_sel), 32'd1);

    // Back to standby, full clean cycle and done hold.
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("menu2.state", 32'(u_if.state), 32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("clean.state", 32'(u_if.state), 32'd3);
    check("clean.rem3", 32'(u_if.remaining_sec), 32'd3);
    step(1, 0, 0, 0);
    check("clean.rem2", 32'(u_if.remaining_sec), 32'd2);
    step(1, 0, 0, 0);
    check("clean.rem1", 32'(u_if.remaining_sec), 32'd1);
    step(1, 0, 0, 0);
    check("clean.rem0", 32'(u_if.remaining_sec), 32'd0);
    check("clean.done_state", 32'(u_if.state), 32'd4);
    check("clean.done_ind", 32'(u_if.clean_done_ind), 32'd1);
    step(1, 0, 0, 0);
    check("hold1.state", 32'(u_if.state), 32'd4);
    step(1, 0, 0, 0);
    check("hold2.state", 32'(u_if.state), 32'd1);

    // Abort cleaning with power.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    check("abort.rem2", 32'(u_if.remaining_sec), 32'd2);
    step(0, 1, 0, 0);
    check("abort.state", 32'(u_if.state), 32'd0);
    check("abort.rem", 32'(u_if.remaining_sec), 32'd0);
    check("abort.act", 32'(u_if.clean_active), 32'd0);

    // Idle timeout, and a menu press restarting the idle count.
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("idle3.state", 32'(u_if.state), 32'd1);
    step(1, 0, 0, 0);
    check("idle4.state", 32'(u_if.state), 32'd0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("idle_menu.state", 32'(u_if.state), 32'd2);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    check("idle_restart.state", 32'(u_if.state), 32'd2);
    step(1, 0, 0, 0);
    check("idle_restart4.state", 32'(u_if.state), 32'd0);

    // Simultaneous presses.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 1);
    check("prio_all.state", 32'(u_if.state), 32'd0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    check("prio_cm.state", 32'(u_if.state), 32'd3);

    // Press and tick together: press wins.
    step(0, 0, 0, 0);
    step(1, 0, 1, 0);
    check("press_tick.rem", 32'(u_if.remaining_sec), 32'd3);

    // Power held through reset release.
    do_reset(1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    check("held.state", 32'(u_if.state), 32'd0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("repress.state", 32'(u_if.state), 32'd1);

    // Reset in the middle of cleaning.
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    check("pre_rst.state", 32'(u_if.state), 32'd3);
    do_reset(0, 0, 0);
    check("rst_clean.rem", 32'(u_if.remaining_sec), 32'd0);
    check("rst_clean.act", 32'(u_if.clean_active), 32'd0);
    check("rst_clean.done", 32'(u_if.clean_done_ind), 32'd0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_clean.after", 32'(u_if.state), 32'd0);

    // Random stimulus against the model.
    begin
      bit t, p, m, c;
      p = 0; m = 0; c = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 399) == 0) begin
          do_reset(p, m, c);
        end else begin
          t = ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 11) == 0) p = !p;
          if ($urandom_range(0, 5) == 0)  m = !m;
          if ($urandom_range(0, 5) == 0)  c = !c;
          step(t, p, m, c);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
